// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the decode stage.
//   - RISC-V major opcodes and funct7 patterns recognised by the decoder
//   - alu_op encodings (identical to the RV funct3 of OP/OP-IMM)
//   - ctrl_t: packed control bundle carried alongside each instruction
//   - imm_fmt_e + imm_gen(): 32-bit immediate extraction per instruction format
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } imm_fmt_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_imm;
        logic       alu_sub;
        logic       alu_sra;
        logic       rd_w;
        logic       ld_upper;
        logic       add_pc;
        logic       jmp_reg;
        logic       is_branch;
        logic       is_jmp;
        logic       is_load;
        logic       is_store;
        logic       is_mul;
        logic       is_word;
        logic       illegal;
    } ctrl_t;

    // Immediate as a sign-correct 32-bit value; the caller widens to XLEN.
    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        imm = 32'b0;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational RISC-V instruction decoder.
//   i_inst  : raw 32-bit instruction word
//   o_ctrl  : control bundle (illegal=1 with all else 0 when unrecognised)
//   o_rd/o_rs1/o_rs2 : raw register index fields
//   o_imm   : sign-extended immediate for the format, 0 for R-type/illegal
// XLEN=64 enables the RV64I *W ops and LD/LWU/SD; EN_M enables MUL/DIV.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b0
) (
    input  logic [31:0]     i_inst,
    output ctrl_t           o_ctrl,
    output logic [4:0]      o_rd,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [XLEN-1:0] o_imm
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_shift_base;
    logic        w_shift_alt;
    logic        w_legal;
    imm_fmt_e    w_fmt;
    ctrl_t       w_ctrl;
    logic [31:0] w_imm32;

    assign w_opcode = i_inst[6:0];
    assign w_f3     = i_inst[14:12];
    assign w_f7     = i_inst[31:25];

    // Immediate shifts: RV64 uses a 6-bit shamt, so only inst[31:26] is the funct field.
    assign w_shift_base = RV64 ? (i_inst[31:26] == 6'b000000) : (w_f7 == F7_BASE);
    assign w_shift_alt  = RV64 ? (i_inst[31:26] == 6'b010000) : (w_f7 == F7_ALT);

    always_comb begin
        w_ctrl  = '0;
        w_fmt   = FMT_R;
        w_legal = 1'b0;
        if (i_inst[1:0] == 2'b11) begin
            case (w_opcode)
                OPC_LUI: begin
                    w_legal = 1'b1;
                    w_ctrl.rd_w = 1'b1;
                    w_ctrl.ld_upper = 1'b1;
                    w_fmt = FMT_U;
                end
                OPC_AUIPC: begin
                    w_legal = 1'b1;
                    w_ctrl.rd_w = 1'b1;
                    w_ctrl.add_pc = 1'b1;
                    w_fmt = FMT_U;
                end
                OPC_JAL: begin
                    w_legal = 1'b1;
                    w_ctrl.rd_w = 1'b1;
                    w_ctrl.is_jmp = 1'b1;
                    w_fmt = FMT_J;
                end
                OPC_JALR: begin
                    w_legal = (w_f3 == 3'b000);
                    w_ctrl.rd_w = 1'b1;
                    w_ctrl.is_jmp = 1'b1;
                    w_ctrl.jmp_reg = 1'b1;
                    w_ctrl.alu_imm = 1'b1;
                    w_fmt = FMT_I;
                end
                OPC_BRANCH: begin
                    w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                    w_ctrl.is_branch = 1'b1;
                    w_fmt = FMT_B;
                end
                OPC_LOAD: begin
                    // LD (011) and LWU (110) exist only on RV64; 111 never.
                    w_legal = (w_f3 != 3'b111) && (RV64 || ((w_f3 != 3'b011) && (w_f3 != 3'b110)));
                    w_ctrl.rd_w = 1'b1;
                    w_ctrl.alu_imm = 1'b1;
                    w_ctrl.is_load = 1'b1;
                    w_fmt = FMT_I;
                end
                OPC_STORE: begin
                    w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                              (RV64 && (w_f3 == 3'b011));
                    w_ctrl.alu_imm = 1'b1;
                    w_ctrl.is_store = 1'b1;
                    w_fmt = FMT_S;
                end
                OPC_OP_IMM: begin
                    case (w_f3)
                        ALU_SLL: w_legal = w_shift_base;
                        ALU_SR:  w_legal = w_shift_base || w_shift_alt;
                        default: w_legal = 1'b1;
                    endcase
                    w_ctrl.alu_op = w_f3;
                    w_ctrl.alu_imm = 1'b1;
                    w_ctrl.rd_w = 1'b1;
                    w_ctrl.alu_sra = (w_f3 == ALU_SR) && w_shift_alt;
                    w_fmt = FMT_I;
                end
                OPC_OP: begin
                    w_ctrl.alu_op = w_f3;
                    w_ctrl.rd_w = 1'b1;
                    if (w_f7 == F7_BASE) begin
                        w_legal = 1'b1;
                    end else if (w_f7 == F7_ALT) begin
                        w_legal = (w_f3 == ALU_ADD) || (w_f3 == ALU_SR);
                        w_ctrl.alu_sub = (w_f3 == ALU_ADD);
                        w_ctrl.alu_sra = (w_f3 == ALU_SR);
                    end else if (w_f7 == F7_MULDIV) begin
                        w_legal = EN_M;
                        w_ctrl.is_mul = 1'b1;
                    end
                end
                OPC_OP_IMM_32: begin
                    case (w_f3)
                        ALU_ADD: w_legal = RV64;
                        ALU_SLL: w_legal = RV64 && (w_f7 == F7_BASE);
                        ALU_SR:  w_legal = RV64 && ((w_f7 == F7_BASE) || (w_f7 == F7_ALT));
                        default: w_legal = 1'b0;
                    endcase
                    w_ctrl.alu_op = w_f3;
                    w_ctrl.alu_imm = 1'b1;
                    w_ctrl.rd_w = 1'b1;
                    w_ctrl.is_word = 1'b1;
                    w_ctrl.alu_sra = (w_f3 == ALU_SR) && (w_f7 == F7_ALT);
                    w_fmt = FMT_I;
                end
                OPC_OP_32: begin
                    w_ctrl.alu_op = w_f3;
                    w_ctrl.rd_w = 1'b1;
                    w_ctrl.is_word = 1'b1;
                    if (w_f7 == F7_BASE) begin
                        w_legal = RV64 && ((w_f3 == ALU_ADD) || (w_f3 == ALU_SLL) || (w_f3 == ALU_SR));
                    end else if (w_f7 == F7_ALT) begin
                        w_legal = RV64 && ((w_f3 == ALU_ADD) || (w_f3 == ALU_SR));
                        w_ctrl.alu_sub = (w_f3 == ALU_ADD);
                        w_ctrl.alu_sra = (w_f3 == ALU_SR);
                    end else if (w_f7 == F7_MULDIV) begin
                        // MULW, DIVW, DIVUW, REMW, REMUW
                        w_legal = RV64 && EN_M && (w_f3 != 3'b001) && (w_f3 != 3'b010) && (w_f3 != 3'b011);
                        w_ctrl.is_mul = 1'b1;
                    end
                end
                default: w_legal = 1'b0;
            endcase
        end
        // Anything not positively recognised collapses to a bare illegal flag.
        if (!w_legal) begin
            w_ctrl = '0;
            w_ctrl.illegal = 1'b1;
            w_fmt = FMT_R;
        end
    end

    assign w_imm32 = imm_gen(i_inst, w_fmt);

    assign o_ctrl = w_ctrl;
    assign o_rd   = i_inst[11:7];
    assign o_rs1  = i_inst[19:15];
    assign o_rs2  = i_inst[24:20];
    assign o_imm  = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: pipeline decode stage with a two-entry (output + skid) buffer.
//   clk, rst       : clock, synchronous active-high reset
//   flush          : drop both buffered bundles and any incoming instruction
//   in_valid/in_ready/in_inst/in_pc : upstream handshake and instruction
//   out_valid/out_ready             : downstream handshake
//   out_pc/out_ctrl/out_rd/out_rs1/out_rs2/out_imm : decoded bundle
// in_ready is registered and equals "skid register empty".
module decode_stage
    import ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output ctrl_t           out_ctrl,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm
);

    localparam int CW = $bits(ctrl_t);
    localparam int BW = 2 * XLEN + 15 + CW;

    ctrl_t           w_ctrl;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_imm;
    logic [BW-1:0]   w_in_bundle;

    ctrl_decode #(
        .XLEN (XLEN),
        .EN_M (EN_M)
    ) u_ctrl_decode (
        .i_inst (in_inst),
        .o_ctrl (w_ctrl),
        .o_rd   (w_rd),
        .o_rs1  (w_rs1),
        .o_rs2  (w_rs2),
        .o_imm  (w_imm)
    );

    assign w_in_bundle = {in_pc, w_imm, w_rd, w_rs1, w_rs2, w_ctrl};

    logic          r_out_valid;
    logic          r_skid_valid;
    logic          r_in_ready;
    logic [BW-1:0] r_out_bundle;
    logic [BW-1:0] r_skid_bundle;

    logic          w_accept;
    logic          w_drain;
    logic          w_out_valid_next;
    logic          w_skid_valid_next;
    logic [BW-1:0] w_out_bundle_next;
    logic [BW-1:0] w_skid_bundle_next;

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = r_out_valid && out_ready;

    always_comb begin
        w_out_valid_next   = r_out_valid;
        w_skid_valid_next  = r_skid_valid;
        w_out_bundle_next  = r_out_bundle;
        w_skid_bundle_next = r_skid_bundle;
        if (!r_out_valid || w_drain) begin
            // Output register is free this edge: the older skid entry wins,
            // otherwise take the incoming instruction directly.
            if (r_skid_valid) begin
                w_out_bundle_next = r_skid_bundle;
                w_out_valid_next  = 1'b1;
                w_skid_valid_next = 1'b0;
            end else if (w_accept) begin
                w_out_bundle_next = w_in_bundle;
                w_out_valid_next  = 1'b1;
            end else begin
                w_out_valid_next  = 1'b0;
            end
        end else if (w_accept) begin
            // Output stalled: park the new bundle in the skid register.
            w_skid_bundle_next = w_in_bundle;
            w_skid_valid_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_out_valid   <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_bundle  <= '0;
            r_skid_bundle <= '0;
        end else begin
            r_out_valid   <= w_out_valid_next;
            r_skid_valid  <= w_skid_valid_next;
            r_in_ready    <= !w_skid_valid_next;
            r_out_bundle  <= w_out_bundle_next;
            r_skid_bundle <= w_skid_bundle_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign {out_pc, out_imm, out_rd, out_rs1, out_rs2, out_ctrl} = r_out_bundle;

endmodule
